// File: rtl/xmit_dma_sequencer.sv
// Transmit DMA sequencer: queues host buffer addresses and launches one mover transfer per entry.
// Optional watchdog per transfer is built when XMIT_DMA_TIMEOUT_EN is defined.
module xmit_dma_sequencer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [63:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [63:0]                   dma_src_address,
    output logic                          dma_start,
    input  logic                          dma_idle,
    output logic [31:0]                   frames_done,
    output logic [15:0]                   zero_drops,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    input  logic                          clear_err,
    output logic                          timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

    state_t        state_q;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   addr_q;
    logic          start_q, busy_q;
    logic [31:0]   frames_q;
    logic [15:0]   drops_q;
    logic          accept, push, zero_beat, pop, in_wait, wd_expired;

    assign s_axis_tready = (count_q != (AW+1)'(FIFO_DEPTH));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign push          = accept & (s_axis_tdata != 64'd0);
    assign zero_beat     = accept & (s_axis_tdata == 64'd0);
    assign pop           = (state_q == S_IDLE) & enable & (count_q != '0) & dma_idle;
    assign in_wait       = (state_q == S_WAIT_BUSY) | (state_q == S_WAIT_IDLE);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is never reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drops_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (zero_beat && drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        addr_q  <= mem_q[rd_ptr_q];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: state_q <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (wd_expired) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!dma_idle) begin
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (wd_expired) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (dma_idle) begin
                        frames_q <= frames_q + 32'd1;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef XMIT_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;

    // Counter is zero outside the wait states, so every launch starts from a clean count.
    assign wd_expired = in_wait & (wd_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= in_wait ? wd_q + TW'(1) : '0;
            if (wd_expired)     err_q <= 1'b1;
            else if (clear_err) err_q <= 1'b0;
        end
    end

    assign timeout_err = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_clear_err;
    logic unused_in_wait;

    assign unused_clear_err = clear_err;
    assign unused_in_wait   = in_wait;
    assign wd_expired       = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign dma_src_address = addr_q;
    assign dma_start       = start_q;
    assign busy            = busy_q;
    assign frames_done     = frames_q;
    assign zero_drops      = drops_q;
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_xmit_dma_sequencer.sv
// Self-checking bench for xmit_dma_sequencer: beat table, address scoreboard and a behavioural mover.
module tb_xmit_dma_sequencer;
`ifdef XMIT_DMA_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 1000000;
`endif
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn, enable, s_axis_tvalid, s_axis_tready;
    logic        dma_start, dma_idle, busy, clear_err, timeout_err;
    logic [63:0] s_axis_tdata, dma_src_address;
    logic [31:0] frames_done;
    logic [15:0] zero_drops;
    logic [4:0]  fifo_count;

    int          compared   = 0;
    int          mismatched = 0;
    longint      cyc        = 0;
    longint      last_start = -100;
    longint      start_cyc  = 0;
    int          starts     = 0;
    int          mover_gap  = 2;
    int          mover_busy = 100;
    bit          mover_hold = 1'b0;
    logic [63:0] sb [$];

    typedef struct {
        logic [63:0] data;
        logic        exp_ready;
        logic [4:0]  exp_count;
        logic [15:0] exp_drops;
    } vec_t;
    vec_t vecs [20];

    xmit_dma_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .dma_src_address(dma_src_address), .dma_start(dma_start), .dma_idle(dma_idle),
        .frames_done(frames_done), .zero_drops(zero_drops), .fifo_count(fifo_count),
        .busy(busy), .clear_err(clear_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Offer one beat for one cycle; the scoreboard learns only stored (accepted, non-zero) addresses.
    task automatic push(input logic [63:0] d, output bit acc);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        acc = s_axis_tready;
        if (acc && d != 64'd0) sb.push_back(d);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        bit acc;
        for (int i = lo; i <= hi; i++) begin
            check($sformatf("vec%0d_tready", i), s_axis_tready, vecs[i].exp_ready);
            push(vecs[i].data, acc);
            check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
            check($sformatf("vec%0d_drops", i), zero_drops, vecs[i].exp_drops);
        end
    endtask

    task automatic wait_frames(input logic [31:0] target, input int budget);
        int n = 0;
        while (frames_done != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_done, target);
    endtask

    // Behavioural mover: drops idle mover_gap cycles after a launch, stays busy mover_busy cycles.
    initial begin
        dma_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn && dma_start) begin
                starts++;
                check("start_gap_ge4", 64'(cyc - last_start >= 4), 64'd1);
                last_start = cyc;
                start_cyc  = cyc;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL start_expected: got launch at 0x%0h, expected none", dma_src_address);
                end else begin
                    check("src_addr", dma_src_address, sb.pop_front());
                end
                repeat (mover_gap) @(negedge clk);
                dma_idle = 1'b0;
                repeat (mover_busy) @(negedge clk);
                while (mover_hold) @(negedge clk);
                dma_idle = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;

        vecs[0] = '{64'h0,    1'b1, 5'd0, 16'd1};
        vecs[1] = '{64'h2000, 1'b1, 5'd1, 16'd1};
        vecs[2] = '{64'h0,    1'b1, 5'd1, 16'd2};
        for (int i = 0; i < 17; i++) begin
            vecs[3+i].data      = 64'h1_0000_0000 + 64'(i + 1) * 64'h40;
            vecs[3+i].exp_ready = (i < DEPTH);
            vecs[3+i].exp_count = (i < DEPTH) ? 5'(i + 1) : 5'(DEPTH);
            vecs[3+i].exp_drops = 16'd2;
        end

        resetn = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dma_start", dma_start, 0);
        check("rst_src_addr", dma_src_address, 0);
        check("rst_frames", frames_done, 0);
        check("rst_drops", zero_drops, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_tready", s_axis_tready, 1);
        resetn = 1'b1;
        @(negedge clk);

        // Single transfer with launch latency: beat accepted at edge M, start visible in cycle M+2.
        enable = 1'b1;
        push(64'h1000_0000, acc);
        check("lat_start_low", dma_start, 0);
        check("lat_count1", fifo_count, 1);
        @(negedge clk);
        check("lat_start_high", dma_start, 1);
        check("lat_busy", busy, 1);
        check("lat_count0", fifo_count, 0);
        @(negedge clk);
        check("start_one_cycle", dma_start, 0);
        wait_frames(32'd1, 400);
        check("single_starts", 64'(starts), 1);
        check("single_addr_hold", dma_src_address, 64'h1000_0000);
        check("single_busy_done", busy, 0);

        // Zero-address filtering.
        enable = 1'b0;
        apply_vecs(0, 2);
        enable = 1'b1;
        wait_frames(32'd2, 400);
        check("zero_starts", 64'(starts), 2);

        // Fill to full with launches inhibited, then drain in order.
        enable = 1'b0;
        mover_busy = 5;
        apply_vecs(3, 19);
        enable = 1'b1;
        wait_frames(32'd18, 2000);
        check("drain_starts", 64'(starts), 18);
        check("drain_count", fifo_count, 0);
        check("drain_sb_empty", 64'(sb.size()), 0);

        // Dropping enable mid-transfer must not abort it, only block the next launch.
        mover_busy = 20;
        push(64'hA000, acc);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        check("mid_busy", busy, 1);
        enable = 1'b0;
        push(64'hB000, acc);
        wait_frames(32'd19, 200);
        check("mid_addr", dma_src_address, 64'hA000);
        repeat (10) @(negedge clk);
        check("mid_no_launch", 64'(starts), 19);
        check("mid_count", fifo_count, 1);

        // Reset while waiting for the mover with five entries queued.
        mover_busy = 200;
        enable = 1'b1;
        n = 0;
        while (!(busy && !dma_idle) && n < 20) begin @(negedge clk); n++; end
        check("rst_mid_in_wait", 64'(busy && !dma_idle), 1);
        for (int i = 0; i < 5; i++) push(64'hC000 + 64'(i) * 64'h100, acc);
        check("rst_mid_count5", fifo_count, 5);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_frames", frames_done, 0);
        check("rst_mid_addr", dma_src_address, 0);
        check("rst_mid_start", dma_start, 0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_rel_tready", s_axis_tready, 1);
        check("rst_rel_count", fifo_count, 0);
        check("rst_rel_drops", zero_drops, 0);
        n = 0;
        while (!dma_idle && n < 400) begin @(negedge clk); n++; end
        check("mover_idle", dma_idle, 1);

`ifdef XMIT_DMA_TIMEOUT_EN
        // Watchdog: mover never returns idle.
        mover_busy = 1;
        mover_hold = 1'b1;
        n = starts;
        push(64'hD000, acc);
        begin
            int k = 0;
            while (starts == n && k < 20) begin @(negedge clk); k++; end
            k = 0;
            while (!timeout_err && k < 300) begin @(negedge clk); k++; end
        end
        check("to_err_set", timeout_err, 1);
        check("to_latency", 64'(cyc - start_cyc), 64'(TO + 1));
        check("to_frames", frames_done, 0);
        check("to_busy", busy, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("to_cleared", timeout_err, 0);
        mover_hold = 1'b0;
        n = 0;
        while (!dma_idle && n < 50) begin @(negedge clk); n++; end
        check("to_mover_idle", dma_idle, 1);
`else
        // No watchdog: the sequencer waits indefinitely and clear_err is ignored.
        mover_busy = 1;
        mover_hold = 1'b1;
        push(64'hD000, acc);
        clear_err = 1'b1;
        repeat (300) @(negedge clk);
        clear_err = 1'b0;
        check("nto_err", timeout_err, 0);
        check("nto_still_busy", busy, 1);
        mover_hold = 1'b0;
        wait_frames(32'd1, 50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
